vend_fsm_change: RTL and testbench

Parametrised coin-operated vending controller: accumulates credit from 5/10/25-unit coins, dispenses one item when credit reaches a programmable price, then returns change one coin per handshake. Supports cancel/refund, rejects coins while busy or on credit overflow, and keeps a wrapping sales counter. Sits between the coin acceptor front end and the dispense/change-hopper actuators.

---
 rtl/vend_fsm_change.sv | 140 ++++++++++++++
 tb/tb_vend_fsm_change.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm_change.sv
// Coin-operated vending controller: accumulates credit from coins, dispenses
// one item at a programmable price, then pays change one coin per handshake.
module vend_fsm_change #(
    parameter int unsigned PRICE      = 3,
    parameter int unsigned MAX_CREDIT = 15,
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                dispense_ack,
    input  logic                change_ack,
    output logic                dispense,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    sales
);

    // Extra headroom so credit + 5 never wraps before the overflow compare.
    localparam int unsigned SUM_W = CREDIT_W + 3;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CREDIT_W-1:0] change_left;
    logic [CREDIT_W-1:0] change_left_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CNT_W-1:0]    sales_nxt;
    logic                reject_nxt;
    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    sum;
    logic                coin_seen;

    // Coin encoding to credit steps, and the widened running sum.
    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = SUM_W'(1);
            2'b10:   coin_val = SUM_W'(2);
            2'b11:   coin_val = SUM_W'(5);
            default: coin_val = '0;
        endcase
        sum       = SUM_W'(credit) + coin_val;
        coin_seen = (coin != 2'b00);
    end

    // Next-state, credit, change and sales decisions.
    always_comb begin
        state_nxt       = state;
        credit_nxt      = credit;
        change_left_nxt = change_left;
        sales_nxt       = sales;
        reject_nxt      = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (cancel) begin
                    reject_nxt = coin_seen;
                    if (credit != '0) begin
                        change_left_nxt = credit;
                        credit_nxt      = '0;
                        state_nxt       = ST_CHANGE;
                    end
                end else if (coin_seen) begin
                    if (sum > SUM_W'(MAX_CREDIT)) begin
                        reject_nxt = 1'b1;
                    end else if (sum >= SUM_W'(PRICE)) begin
                        credit_nxt      = '0;
                        change_left_nxt = CREDIT_W'(sum - SUM_W'(PRICE));
                        state_nxt       = ST_DISPENSE;
                    end else begin
                        credit_nxt = CREDIT_W'(sum);
                    end
                end
            end
            ST_DISPENSE: begin
                reject_nxt = coin_seen;
                if (dispense_ack) begin
                    sales_nxt = sales + CNT_W'(1);
                    state_nxt = (change_left != '0) ? ST_CHANGE : ST_COLLECT;
                end
            end
            ST_CHANGE: begin
                reject_nxt = coin_seen;
                if (change_ack) begin
                    if (change_left >= CREDIT_W'(2)) begin
                        change_left_nxt = change_left - CREDIT_W'(2);
                    end else begin
                        change_left_nxt = change_left - CREDIT_W'(1);
                    end
                    if (change_left_nxt == '0) begin
                        state_nxt = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_nxt = ST_COLLECT;
            end
        endcase
    end

    // State and registered outputs; actuator outputs track the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_COLLECT;
            credit       <= '0;
            change_left  <= '0;
            sales        <= '0;
            coin_reject  <= 1'b0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= 2'b00;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            change_left  <= change_left_nxt;
            sales        <= sales_nxt;
            coin_reject  <= reject_nxt;
            dispense     <= (state_nxt == ST_DISPENSE);
            change_valid <= (state_nxt == ST_CHANGE);
            busy         <= (state_nxt != ST_COLLECT);
            if (state_nxt == ST_CHANGE) begin
                change_coin <= (change_left_nxt >= CREDIT_W'(2)) ? 2'b10 : 2'b01;
            end else begin
                change_coin <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_vend_fsm_change.sv
// Self-checking bench for vend_fsm_change: directed scenarios followed by
// random coins/cancels/acks, all checked against a transaction-level model.
module tb_vend_fsm_change;

    localparam int unsigned PRICE      = 3;
    localparam int unsigned MAX_CREDIT = 6;
    localparam int unsigned CREDIT_W   = 4;
    localparam int unsigned CNT_W      = 2;

    logic                clk;
    logic                rst;
    logic [1:0]          coin;
    logic                cancel;
    logic                dispense_ack;
    logic                change_ack;
    logic                dispense;
    logic                change_valid;
    logic [1:0]          change_coin;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic [CNT_W-1:0]    sales;

    int n_vec;
    int n_err;

    // Reference model: what the customer sees, in plain integers.
    int m_phase;   // 0 waiting for money, 1 item pending, 2 paying change
    int m_credit;
    int m_owed;
    int m_sales;
    int m_rej;

    vend_fsm_change #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .cancel       (cancel),
        .dispense_ack (dispense_ack),
        .change_ack   (change_ack),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .coin_reject  (coin_reject),
        .busy         (busy),
        .credit       (credit),
        .sales        (sales)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_credit = 0;
        m_owed   = 0;
        m_sales  = 0;
        m_rej    = 0;
    endtask

    // Apply one clock's worth of customer/actuator activity to the model.
    task automatic model_step(input int c, input bit cn, input bit da, input bit ca);
        int val;
        int total;
        val   = (c == 1) ? 1 : (c == 2) ? 2 : (c == 3) ? 5 : 0;
        m_rej = 0;
        if (m_phase == 0) begin
            if (cn) begin
                m_rej = (val != 0);
                if (m_credit > 0) begin
                    m_owed   = m_credit;
                    m_credit = 0;
                    m_phase  = 2;
                end
            end else if (val != 0) begin
                total = m_credit + val;
                if (total > int'(MAX_CREDIT)) begin
                    m_rej = 1;
                end else if (total >= int'(PRICE)) begin
                    m_credit = 0;
                    m_owed   = total - int'(PRICE);
                    m_phase  = 1;
                end else begin
                    m_credit = total;
                end
            end
        end else if (m_phase == 1) begin
            m_rej = (val != 0);
            if (da) begin
                m_sales = (m_sales + 1) % (1 << CNT_W);
                m_phase = (m_owed > 0) ? 2 : 0;
            end
        end else begin
            m_rej = (val != 0);
            if (ca) begin
                m_owed = m_owed - ((m_owed >= 2) ? 2 : 1);
                if (m_owed == 0) m_phase = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int exp_coin;
        exp_coin = (m_phase == 2) ? ((m_owed >= 2) ? 2 : 1) : 0;
        chk({tag, ".dispense"},     32'(dispense),     32'(m_phase == 1));
        chk({tag, ".change_valid"}, 32'(change_valid), 32'(m_phase == 2));
        chk({tag, ".change_coin"},  32'(change_coin),  32'(exp_coin));
        chk({tag, ".busy"},         32'(busy),         32'(m_phase != 0));
        chk({tag, ".coin_reject"},  32'(coin_reject),  32'(m_rej));
        chk({tag, ".credit"},       32'(credit),       32'(m_credit));
        chk({tag, ".sales"},        32'(sales),        32'(m_sales));
    endtask

    // Called at a falling edge: drive inputs, clock once, check at next fall.
    task automatic cycle(input string tag, input logic [1:0] c, input logic cn,
                         input logic da, input logic ca);
        coin         = c;
        cancel       = cn;
        dispense_ack = da;
        change_ack   = ca;
        @(posedge clk);
        model_step(int'(c), cn, da, ca);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b0;
        coin         = 2'b00;
        cancel       = 1'b0;
        dispense_ack = 1'b0;
        change_ack   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        cycle("idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // Exact payment with three 5-unit coins.
        cycle("exact1", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("exact1_credit", 32'(credit), 32'd1);
        cycle("exact2", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("exact2_credit", 32'(credit), 32'd2);
        cycle("exact3", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("exact3_dispense", 32'(dispense), 32'd1);
        chk("exact3_credit", 32'(credit), 32'd0);
        cycle("exact_ack", 2'b00, 1'b0, 1'b1, 1'b0);
        chk("exact_sales", 32'(sales), 32'd1);
        chk("exact_no_change", 32'(change_valid), 32'd0);

        // Overpay with a 25 gives one 10-unit change coin.
        cycle("over_coin", 2'b11, 1'b0, 1'b0, 1'b0);
        cycle("over_dack", 2'b00, 1'b0, 1'b1, 1'b0);
        chk("over_coin10", 32'(change_coin), 32'd2);
        cycle("over_cack", 2'b00, 1'b0, 1'b0, 1'b1);
        chk("over_idle", 32'(busy), 32'd0);
        chk("over_sales", 32'(sales), 32'd2);

        // Cancel with a simultaneous coin: coin refused, credit refunded.
        cycle("cancel_coin", 2'b10, 1'b0, 1'b0, 1'b0);
        cycle("cancel_req", 2'b01, 1'b1, 1'b0, 1'b0);
        chk("cancel_reject", 32'(coin_reject), 32'd1);
        chk("cancel_coin10", 32'(change_coin), 32'd2);
        cycle("cancel_cack", 2'b00, 1'b0, 1'b0, 1'b1);
        chk("cancel_sales", 32'(sales), 32'd2);

        // Overflow: 10 then 25 exceeds the credit ceiling.
        cycle("ovf_a", 2'b10, 1'b0, 1'b0, 1'b0);
        cycle("ovf_b", 2'b11, 1'b0, 1'b0, 1'b0);
        chk("ovf_reject", 32'(coin_reject), 32'd1);
        chk("ovf_credit", 32'(credit), 32'd2);
        cycle("ovf_c", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("ovf_dispense", 32'(dispense), 32'd1);
        cycle("ovf_dack", 2'b00, 1'b0, 1'b1, 1'b0);

        // Coin offered while busy, then back-to-back reject pulses.
        cycle("busy_a", 2'b01, 1'b0, 1'b0, 1'b0);
        cycle("busy_b", 2'b10, 1'b0, 1'b0, 1'b0);
        cycle("busy_rej1", 2'b10, 1'b0, 1'b0, 1'b0);
        cycle("busy_rej2", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("busy_reject", 32'(coin_reject), 32'd1);
        cycle("busy_dack", 2'b00, 1'b0, 1'b1, 1'b0);
        chk("busy_pulse_end", 32'(coin_reject), 32'd0);

        // Four vends to walk the 2-bit sales counter through its wrap.
        for (int v = 0; v < 4; v++) begin
            cycle("wrap_a", 2'b10, 1'b0, 1'b0, 1'b0);
            cycle("wrap_b", 2'b01, 1'b0, 1'b0, 1'b0);
            cycle("wrap_ack", 2'b00, 1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of paying change.
        cycle("rst_coin", 2'b11, 1'b0, 1'b0, 1'b0);
        cycle("rst_dack", 2'b00, 1'b0, 1'b1, 1'b0);
        chk("rst_pre_cv", 32'(change_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst = 1'b1;
        cycle("rst_after", 2'b00, 1'b0, 1'b0, 1'b0);

        // Random traffic; acks are offered regardless of their valid.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] rc;
            logic       rcn;
            logic       rda;
            logic       rca;
            rc  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rcn = ($urandom_range(0, 9) == 0);
            rda = ($urandom_range(0, 2) == 0);
            rca = ($urandom_range(0, 2) == 0);
            cycle("rand", rc, rcn, rda, rca);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
